// File: rtl/mac_datapath.sv
// Per-neuron MAC datapath: aligns controller strobes to memory read latency,
// multiplies pixel x weight, accumulates a run and emits a biased result.
module mac_datapath #(
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned ACC_W          = 32,
  parameter int unsigned EXPECTED_TERMS = 784
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_acc,
  input  logic                    valid_mac,
  input  logic                    done,
  input  logic [7:0]              pixel_data,
  input  logic [7:0]              weight_data,
  input  logic signed [ACC_W-1:0] bias,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  output logic                    overflow,
  output logic                    count_err
);

  localparam int unsigned PROD_W = 17;
  // Wide enough that the saturated (all-ones) count never equals EXPECTED_TERMS.
  localparam int unsigned CNT_W  = $clog2(EXPECTED_TERMS + 2);

  logic [READ_LATENCY-1:0] r_clr_sr;
  logic [READ_LATENCY-1:0] r_v_sr;
  logic [READ_LATENCY-1:0] r_done_sr;
  logic                    r_done_dd;
  logic                    r_pv;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_sticky;
  logic signed [ACC_W-1:0] r_result;
  logic                    r_result_valid;
  logic                    r_overflow;
  logic                    r_count_err;

  logic                    w_clr_d;
  logic                    w_v_d;
  logic                    w_done_d;
  logic signed [PROD_W-1:0] w_mult;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic                    w_acc_ovf;
  logic signed [ACC_W-1:0] w_fin_sum;
  logic                    w_fin_ovf;
  logic [CNT_W-1:0]        w_cnt_inc;

  assign w_clr_d  = r_clr_sr[READ_LATENCY-1];
  assign w_v_d    = r_v_sr[READ_LATENCY-1];
  assign w_done_d = r_done_sr[READ_LATENCY-1];

  // Pixel is unsigned, so it is zero-extended into the signed product.
  assign w_mult     = PROD_W'($signed({1'b0, pixel_data})) * PROD_W'($signed(weight_data));
  assign w_prod_ext = ACC_W'(r_prod);

  assign w_acc_sum = r_acc + w_prod_ext;
  assign w_acc_ovf = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                     (w_acc_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_fin_sum = r_acc + bias;
  assign w_fin_ovf = (r_acc[ACC_W-1] == bias[ACC_W-1]) &&
                     (w_fin_sum[ACC_W-1] != r_acc[ACC_W-1]);
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

  // Align controller strobes with the memory read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_sr  <= '0;
      r_v_sr    <= '0;
      r_done_sr <= '0;
      r_done_dd <= 1'b0;
    end else begin
      r_clr_sr[0]  <= clr_acc;
      r_v_sr[0]    <= valid_mac;
      r_done_sr[0] <= done;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_clr_sr[i]  <= r_clr_sr[i-1];
        r_v_sr[i]    <= r_v_sr[i-1];
        r_done_sr[i] <= r_done_sr[i-1];
      end
      r_done_dd <= w_done_d;
    end
  end

  // Multiply stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pv   <= 1'b0;
    end else begin
      r_pv <= w_v_d;
      if (w_v_d) begin
        r_prod <= w_mult;
      end
    end
  end

  // Accumulate stage; a clear wins over a plain accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (w_clr_d && r_pv) begin
      r_acc    <= w_prod_ext;
      r_cnt    <= CNT_W'(1);
      r_sticky <= 1'b0;
    end else if (w_clr_d) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else if (r_pv) begin
      r_acc    <= w_acc_sum;
      r_cnt    <= w_cnt_inc;
      r_sticky <= r_sticky | w_acc_ovf;
    end
  end

  // Finalize: samples acc on the same edge a following clear lands, so it sees the old run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_count_err    <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (r_done_dd) begin
        r_result       <= w_fin_sum;
        r_overflow     <= r_sticky | w_fin_ovf;
        r_count_err    <= (r_cnt != CNT_W'(EXPECTED_TERMS));
        r_result_valid <= 1'b1;
      end
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;
  assign count_err    = r_count_err;

endmodule
